// File: rtl/fetch_sequencer.sv
// Multi-cycle PC/phase sequencer for the 8-bit accumulator core: FETCH -> EXEC -> optional MEM.
// Optional executed-cycle counter is built only when CYCLE_COUNT_EN is defined.
module fetch_sequencer #(
  parameter int PC_W        = 10,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            start_i,
  input  logic [PC_W-1:0] start_pc_i,
  input  logic            branchf_i,
  input  logic            branchb_i,
  input  logic            done_i,
  input  logic            memread_i,
  input  logic            memwrite_i,
  input  logic [PC_W-1:0] offset_i,
  input  logic            mem_ack_i,
  output logic [PC_W-1:0] pc_o,
  output logic            inst_en_o,
  output logic            commit_o,
  output logic            mem_req_o,
  output logic            halted_o,
  output logic            error_o,
  output logic [15:0]     cycle_count_o,
  output logic [2:0]      state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  localparam int TMO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  // Last MEM cycle index that may still wait for an ack.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              mem_req_q, mem_req_d;
  logic              halted_q, halted_d;
  logic              error_q, error_d;
  logic              commit;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      tmo_q     <= '0;
      mem_req_q <= 1'b0;
      halted_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tmo_q     <= tmo_d;
      mem_req_q <= mem_req_d;
      halted_q  <= halted_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tmo_d     = tmo_q;
    mem_req_d = mem_req_q;
    halted_d  = halted_q;
    error_d   = error_q;
    commit    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          pc_d    = start_pc_i;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (done_i) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else if (memread_i || memwrite_i) begin
          mem_req_d = 1'b1;
          tmo_d     = '0;
          state_d   = S_MEM;
        end else begin
          // PC arithmetic wraps modulo 2^PC_W in both directions.
          if (branchf_i)      pc_d = pc_q + offset_i;
          else if (branchb_i) pc_d = pc_q - offset_i;
          else                pc_d = pc_q + PC_W'(1);
          commit  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        // An ack in the final allowed cycle still retires the access.
        if (mem_ack_i) begin
          commit    = 1'b1;
          mem_req_d = 1'b0;
          pc_d      = pc_q + PC_W'(1);
          state_d   = S_FETCH;
        end else if (tmo_q == TMO_LAST) begin
          error_d   = 1'b1;
          halted_d  = 1'b1;
          mem_req_d = 1'b0;
          state_d   = S_HALT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_HALT: begin
        if (start_i) begin
          halted_d = 1'b0;
          pc_d     = start_pc_i;
          state_d  = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef CYCLE_COUNT_EN
  logic [15:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if ((state_q == S_FETCH || state_q == S_EXEC || state_q == S_MEM) && cyc_q != 16'hFFFF)
      cyc_d = cyc_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) cyc_q <= '0;
    else          cyc_q <= cyc_d;
  end

  assign cycle_count_o = cyc_q;
`else
  assign cycle_count_o = '0;
`endif

  assign pc_o      = pc_q;
  assign inst_en_o = (state_q == S_FETCH);
  // A reset edge drops any in-flight instruction, so it never commits.
  assign commit_o  = commit & rst_n_i;
  assign mem_req_o = mem_req_q;
  assign halted_o  = halted_q;
  assign error_o   = error_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a vector table for the main instruction flow
// plus hand-written timeout, ack-at-timeout and reset-in-MEM sequences.
module tb_fetch_sequencer;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n, start, bf, bb, dn, mr, mw, ack;
  logic [9:0]  spc, off;
  logic [9:0]  pc_o;
  logic        inst_en_o, commit_o, mem_req_o, halted_o, error_o;
  logic [15:0] cycle_count_o;
  logic [2:0]  state_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.PC_W(10), .MEM_TIMEOUT(15)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .start_pc_i(spc),
    .branchf_i(bf), .branchb_i(bb), .done_i(dn), .memread_i(mr), .memwrite_i(mw),
    .offset_i(off), .mem_ack_i(ack), .pc_o(pc_o), .inst_en_o(inst_en_o),
    .commit_o(commit_o), .mem_req_o(mem_req_o), .halted_o(halted_o),
    .error_o(error_o), .cycle_count_o(cycle_count_o), .state_o(state_o)
  );

  typedef struct {
    logic       start;
    logic [9:0] spc;
    logic       bf, bb, dn, mr, mw;
    logic [9:0] off;
    logic       ack;
    logic [9:0] e_pc;
    logic       e_ien, e_cmt, e_mreq, e_hlt, e_err;
    logic [2:0] e_st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic [9:0] sp, logic f, logic b, logic d,
                              logic r, logic w, logic [9:0] o, logic a,
                              logic [9:0] epc, logic eien, logic ecmt, logic emreq,
                              logic ehlt, logic eerr, logic [2:0] est);
    vec_t v;
    v.start = st; v.spc = sp; v.bf = f; v.bb = b; v.dn = d; v.mr = r; v.mw = w;
    v.off = o; v.ack = a; v.e_pc = epc; v.e_ien = eien; v.e_cmt = ecmt;
    v.e_mreq = emreq; v.e_hlt = ehlt; v.e_err = eerr; v.e_st = est;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    start = 0; spc = '0; bf = 0; bb = 0; dn = 0; mr = 0; mw = 0; off = '0; ack = 0;
  endtask

  task automatic chk_all(string tag, logic [9:0] epc, logic eien, logic ecmt,
                         logic emreq, logic ehlt, logic eerr, logic [2:0] est);
    chk({tag, "_pc"}, 32'(pc_o), 32'(epc));
    chk({tag, "_inst_en"}, 32'(inst_en_o), 32'(eien));
    chk({tag, "_commit"}, 32'(commit_o), 32'(ecmt));
    chk({tag, "_mem_req"}, 32'(mem_req_o), 32'(emreq));
    chk({tag, "_halted"}, 32'(halted_o), 32'(ehlt));
    chk({tag, "_error"}, 32'(error_o), 32'(eerr));
    chk({tag, "_state"}, 32'(state_o), 32'(est));
  endtask

  logic [15:0] exp_cnt;

  initial begin
    //          st sp      f b d r w off     a  pc      ien cmt mrq hlt err state
    vecs.push_back(mk(0, 10'h000, 0,0,0,0,0, 10'h000, 0, 10'h000, 0,0,0,0,0, S_IDLE));
    vecs.push_back(mk(1, 10'h020, 0,0,0,0,0, 10'h000, 0, 10'h000, 0,0,0,0,0, S_IDLE));
    vecs.push_back(mk(0, 10'h000, 0,0,0,0,0, 10'h000, 0, 10'h020, 1,0,0,0,0, S_FETCH));
    vecs.push_back(mk(0, 10'h000, 0,0,0,0,0, 10'h000, 0, 10'h020, 0,1,0,0,0, S_EXEC));
    vecs.push_back(mk(0, 10'h000, 0,0,0,0,0, 10'h000, 0, 10'h021, 1,0,0,0,0, S_FETCH));
    vecs.push_back(mk(0, 10'h000, 0,0,0,0,0, 10'h000, 0, 10'h021, 0,1,0,0,0, S_EXEC));
    vecs.push_back(mk(0, 10'h000, 0,0,0,0,0, 10'h000, 0, 10'h022, 1,0,0,0,0, S_FETCH));
    vecs.push_back(mk(0, 10'h000, 0,0,0,0,0, 10'h000, 0, 10'h022, 0,1,0,0,0, S_EXEC));
    // start ignored in FETCH/EXEC; both branches high -> forward wins (0x023+0xDD=0x100)
    vecs.push_back(mk(1, 10'h3FF, 0,0,0,0,0, 10'h000, 0, 10'h023, 1,0,0,0,0, S_FETCH));
    vecs.push_back(mk(1, 10'h3FF, 1,1,0,0,0, 10'h0DD, 0, 10'h023, 0,1,0,0,0, S_EXEC));
    vecs.push_back(mk(0, 10'h000, 0,0,0,0,0, 10'h000, 0, 10'h100, 1,0,0,0,0, S_FETCH));
    vecs.push_back(mk(0, 10'h000, 1,0,0,0,0, 10'h005, 0, 10'h100, 0,1,0,0,0, S_EXEC));
    vecs.push_back(mk(0, 10'h000, 0,0,0,0,0, 10'h000, 0, 10'h105, 1,0,0,0,0, S_FETCH));
    vecs.push_back(mk(0, 10'h000, 0,1,0,0,0, 10'h102, 0, 10'h105, 0,1,0,0,0, S_EXEC));
    vecs.push_back(mk(0, 10'h000, 0,0,0,0,0, 10'h000, 0, 10'h003, 1,0,0,0,0, S_FETCH));
    vecs.push_back(mk(0, 10'h000, 0,1,0,0,0, 10'h005, 0, 10'h003, 0,1,0,0,0, S_EXEC));
    vecs.push_back(mk(0, 10'h000, 0,0,0,0,0, 10'h000, 0, 10'h3FE, 1,0,0,0,0, S_FETCH));
    vecs.push_back(mk(0, 10'h000, 0,0,0,0,0, 10'h055, 0, 10'h3FE, 0,1,0,0,0, S_EXEC));
    vecs.push_back(mk(0, 10'h000, 0,0,0,0,0, 10'h000, 0, 10'h3FF, 1,0,0,0,0, S_FETCH));
    vecs.push_back(mk(0, 10'h000, 0,0,0,0,0, 10'h000, 0, 10'h3FF, 0,1,0,0,0, S_EXEC));
    vecs.push_back(mk(0, 10'h000, 0,0,0,0,0, 10'h000, 0, 10'h000, 1,0,0,0,0, S_FETCH));
    // load: ack on third MEM cycle
    vecs.push_back(mk(0, 10'h000, 0,0,0,1,0, 10'h000, 0, 10'h000, 0,0,0,0,0, S_EXEC));
    vecs.push_back(mk(1, 10'h2AA, 0,0,0,0,0, 10'h000, 0, 10'h000, 0,0,1,0,0, S_MEM));
    vecs.push_back(mk(0, 10'h000, 0,0,0,0,0, 10'h000, 0, 10'h000, 0,0,1,0,0, S_MEM));
    vecs.push_back(mk(0, 10'h000, 0,0,0,0,0, 10'h000, 1, 10'h000, 0,1,1,0,0, S_MEM));
    vecs.push_back(mk(0, 10'h000, 0,0,0,0,0, 10'h000, 0, 10'h001, 1,0,0,0,0, S_FETCH));
    // store beats branch; ack on first MEM cycle
    vecs.push_back(mk(0, 10'h000, 1,0,0,0,1, 10'h007, 0, 10'h001, 0,0,0,0,0, S_EXEC));
    vecs.push_back(mk(0, 10'h000, 0,0,0,0,0, 10'h000, 1, 10'h001, 0,1,1,0,0, S_MEM));
    vecs.push_back(mk(0, 10'h000, 0,0,0,0,0, 10'h000, 0, 10'h002, 1,0,0,0,0, S_FETCH));
    vecs.push_back(mk(0, 10'h000, 1,0,0,0,0, 10'h03E, 0, 10'h002, 0,1,0,0,0, S_EXEC));
    vecs.push_back(mk(0, 10'h000, 0,0,0,0,0, 10'h000, 0, 10'h040, 1,0,0,0,0, S_FETCH));
    // done beats memread and branch
    vecs.push_back(mk(0, 10'h000, 1,0,1,1,0, 10'h003, 0, 10'h040, 0,0,0,0,0, S_EXEC));
    vecs.push_back(mk(0, 10'h000, 0,0,0,0,0, 10'h000, 0, 10'h040, 0,0,0,1,0, S_HALT));
    vecs.push_back(mk(1, 10'h123, 0,0,0,0,0, 10'h000, 0, 10'h040, 0,0,0,1,0, S_HALT));
    vecs.push_back(mk(0, 10'h000, 0,0,0,0,0, 10'h000, 0, 10'h123, 1,0,0,0,0, S_FETCH));
    vecs.push_back(mk(0, 10'h000, 0,0,0,0,0, 10'h000, 0, 10'h123, 0,1,0,0,0, S_EXEC));
    vecs.push_back(mk(0, 10'h000, 0,0,0,0,0, 10'h000, 0, 10'h124, 1,0,0,0,0, S_FETCH));

    clr();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;

    foreach (vecs[i]) begin
      start = vecs[i].start; spc = vecs[i].spc; bf = vecs[i].bf; bb = vecs[i].bb;
      dn = vecs[i].dn; mr = vecs[i].mr; mw = vecs[i].mw; off = vecs[i].off;
      ack = vecs[i].ack;
      #1;
      chk_all($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_ien, vecs[i].e_cmt,
              vecs[i].e_mreq, vecs[i].e_hlt, vecs[i].e_err, vecs[i].e_st);
      tick();
    end
    clr();

    // Timeout: load with no ack, start mid-wait ignored.
    mr = 1;
    #1;
    chk_all("to_exec", 10'h124, 0, 0, 0, 0, 0, S_EXEC);
    tick();
    mr = 0;
    for (int i = 0; i < 15; i++) begin
      start = (i == 5);
      spc   = 10'h0AA;
      #1;
      chk_all($sformatf("to_mem%0d", i), 10'h124, 0, 0, 1, 0, 0, S_MEM);
      tick();
    end
    clr();
    #1;
    chk_all("to_halt", 10'h124, 0, 0, 0, 1, 1, S_HALT);
    start = 1; spc = 10'h000;
    tick();
    clr();
    #1;
    chk_all("to_restart", 10'h000, 1, 0, 0, 0, 1, S_FETCH);
    tick();

    // Ack arriving in the last allowed MEM cycle retires the load.
    mr = 1;
    tick();
    mr = 0;
    for (int i = 0; i < 14; i++) tick();
    ack = 1;
    #1;
    chk_all("lastack_mem", 10'h000, 0, 1, 1, 0, 1, S_MEM);
    tick();
    ack = 0;
    #1;
    chk_all("lastack_fetch", 10'h001, 1, 0, 0, 0, 1, S_FETCH);
    tick();

    // Reset while in MEM, ack the following cycle.
    mw = 1;
    tick();
    mw = 0;
    rst_n = 0;
    #1;
    chk_all("rstmem_pre", 10'h001, 0, 0, 1, 0, 1, S_MEM);
    tick();
    rst_n = 1;
    ack = 1;
    #1;
    chk_all("rstmem_post", 10'h000, 0, 0, 0, 0, 0, S_IDLE);
    chk("rstmem_cycles", 32'(cycle_count_o), 32'h0);
    tick();
    ack = 0;
    #1;
    chk_all("rstmem_idle", 10'h000, 0, 0, 0, 0, 0, S_IDLE);

    // Two ALU instructions after restart: 4 counted cycles.
    start = 1; spc = 10'h010;
    tick();
    start = 0;
    for (int i = 0; i < 4; i++) tick();
`ifdef CYCLE_COUNT_EN
    exp_cnt = 16'd4;
`else
    exp_cnt = 16'd0;
`endif
    #1;
    chk_all("cnt_fetch", 10'h012, 1, 0, 0, 0, 0, S_FETCH);
    chk("cnt_value", 32'(cycle_count_o), 32'(exp_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
